// File: rtl/io_periph_pkg.sv
// io_pkg: shared constants for the memory-mapped IO responder.
//   - Register offsets relative to the IO window base.
//   - Hex-digit to seven-segment lookup (active-low, bit 7 = dp, kept off).
//   - Reset values for the display drivers.
package io_pkg;

    localparam logic [31:0] IO_LED   = 32'h0000_0060;
    localparam logic [31:0] IO_SEG   = 32'h0000_0064;
    localparam logic [31:0] IO_SEGEN = 32'h0000_0068;
    localparam logic [31:0] IO_BTN   = 32'h0000_0074;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [7:0] SEGEN_RST = 8'hFF;

    // Index = nibble value; listed from F down to 0 so HEX_SEG[n] is digit n.
    // Segment order within each byte is {dp, g, f, e, d, c, b, a}, all active-low.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/io_periph_if.sv
// io_periph_if: CPU <-> IO responder bus.
//   ioRead / ioWrite : single-cycle access strobes from the CPU
//   addr             : byte address (ALU result)
//   w_data           : store data, meaningful only with ioWrite
//   kdata / bdata    : read halves returned by the peripheral, always driven
// master = CPU side, slave = peripheral side.
interface io_periph_if;
    logic        ioRead;
    logic        ioWrite;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [15:0] kdata;
    logic [15:0] bdata;

    modport master (
        output ioRead, ioWrite, addr, w_data,
        input  kdata, bdata
    );

    modport slave (
        input  ioRead, ioWrite, addr, w_data,
        output kdata, bdata
    );
endinterface

// File: rtl/io_periph_debouncer.sv
// debouncer: one button input.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : raw asynchronous pin
//   dout       : debounced level
// A 2-FF synchronizer feeds a counter that must see the synced value differ
// from the accepted level for DEBOUNCE_CYCLES consecutive cycles before the
// accepted level flips. Any return to the accepted level restarts the count.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/io_periph.sv
// io_periph: memory-mapped IO responder.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : io_periph_if.slave (ioRead, ioWrite, addr, w_data in;
//                kdata = synced switches, bdata = buttons + sticky flags out)
//   sw         : raw switch pins
//   btn        : raw button pins, active-high
//   led        : LED register
//   seg_an     : digit anodes, active-low
//   seg_cat    : segment cathodes, active-low, dp always off
module io_periph
    import io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FC00,
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter int          SCAN_DIV        = 100_000
) (
    input  logic        clk,
    input  logic        rst_n,
    io_periph_if.slave  bus,
    input  logic [15:0] sw,
    input  logic [4:0]  btn,
    output logic [15:0] led,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cat
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [15:0] led_q, led_d;
    logic [31:0] seg_val_q, seg_val_d;
    logic [7:0]  seg_en_q, seg_en_d;
    logic [15:0] sw_s1_q, sw_s2_q;
    logic [4:0]  btn_stable;
    logic [4:0]  btn_prev_q;
    logic [4:0]  flag_q, flag_d;
    logic [4:0]  btn_rise, flag_vis;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]  digit_q, digit_d;
    logic [7:0]  seg_an_q, seg_an_d;
    logic [7:0]  seg_cat_q, seg_cat_d;
    logic        wr_led, wr_seg, wr_segen, rd_btn;

    for (genvar i = 0; i < 5; i++) begin : g_btn
        debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (btn[i]),
            .dout (btn_stable[i])
        );
    end

    always_comb begin
        wr_led   = bus.ioWrite && (bus.addr == BASE_ADDR + IO_LED);
        wr_seg   = bus.ioWrite && (bus.addr == BASE_ADDR + IO_SEG);
        wr_segen = bus.ioWrite && (bus.addr == BASE_ADDR + IO_SEGEN);
        rd_btn   = bus.ioRead  && (bus.addr == BASE_ADDR + IO_BTN);
    end

    // Register writes.
    always_comb begin
        led_d     = wr_led   ? bus.w_data[15:0] : led_q;
        seg_val_d = wr_seg   ? bus.w_data       : seg_val_q;
        seg_en_d  = wr_segen ? bus.w_data[7:0]  : seg_en_q;
    end

    // A rise of the debounced level is visible in bdata on the very edge it
    // happens, before flag_q can capture it one edge later. Treating the rise
    // as part of the flag makes a clear on the rising edge lose to the set,
    // while a clear on any later edge drops it.
    always_comb begin
        btn_rise = btn_stable & ~btn_prev_q;
        flag_vis = flag_q | btn_rise;
        flag_d   = rd_btn ? 5'b0 : flag_vis;
    end

    // Display scan: the anode/cathode registers sample digit_q, so they trail
    // it by one cycle but always switch together.
    always_comb begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        digit_d = (presc_q == PRESC_LAST) ? digit_q + 3'd1 : digit_q;
        seg_an_d  = seg_en_q[digit_q] ? ~(8'h01 << digit_q) : SEG_OFF;
        seg_cat_d = HEX_SEG[seg_val_q[{digit_q, 2'b00} +: 4]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q      <= '0;
            seg_val_q  <= '0;
            seg_en_q   <= SEGEN_RST;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            btn_prev_q <= '0;
            flag_q     <= '0;
            presc_q    <= '0;
            digit_q    <= '0;
            seg_an_q   <= SEG_OFF;
            seg_cat_q  <= SEG_OFF;
        end else begin
            led_q      <= led_d;
            seg_val_q  <= seg_val_d;
            seg_en_q   <= seg_en_d;
            sw_s1_q    <= sw;
            sw_s2_q    <= sw_s1_q;
            btn_prev_q <= btn_stable;
            flag_q     <= flag_d;
            presc_q    <= presc_d;
            digit_q    <= digit_d;
            seg_an_q   <= seg_an_d;
            seg_cat_q  <= seg_cat_d;
        end
    end

    assign bus.kdata = sw_s2_q;
    assign bus.bdata = {3'b000, flag_vis, 3'b000, btn_stable};
    assign led       = led_q;
    assign seg_an    = seg_an_q;
    assign seg_cat   = seg_cat_q;

endmodule

// File: tb/tb_io_periph.sv
module tb_io_periph;

    localparam logic [31:0] BASE = 32'hFFFF_FC00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic [15:0] led;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] cat;
    } scan_t;

    logic [15:0] exp_q[$];
    scan_t       scan_q[$];

    localparam logic [7:0] SEG_TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    io_periph_if bus_if ();

    io_periph #(
        .BASE_ADDR      (BASE),
        .DEBOUNCE_CYCLES(4),
        .SCAN_DIV       (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus_if),
        .sw     (sw),
        .btn    (btn),
        .led    (led),
        .seg_an (seg_an),
        .seg_cat(seg_cat)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        bus_if.ioRead  = 1'b0;
        bus_if.ioWrite = 1'b0;
        bus_if.addr    = 32'h0;
        bus_if.w_data  = 32'h0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        bus_if.ioWrite = 1'b1;
        bus_if.addr    = a;
        bus_if.w_data  = d;
        tick();
        bus_if.ioWrite = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        sw    = 16'h0;
        btn   = 5'h0;
        bus_idle();
        repeat (3) tick();
        checks++; if (led !== 16'h0)     begin failures++; $display("FAIL reset_led got=%h exp=%h", led, 16'h0); end
        checks++; if (seg_an !== 8'hFF)  begin failures++; $display("FAIL reset_seg_an got=%h exp=%h", seg_an, 8'hFF); end
        checks++; if (seg_cat !== 8'hFF) begin failures++; $display("FAIL reset_seg_cat got=%h exp=%h", seg_cat, 8'hFF); end
        checks++; if (bus_if.kdata !== 16'h0) begin failures++; $display("FAIL reset_kdata got=%h exp=%h", bus_if.kdata, 16'h0); end
        checks++; if (bus_if.bdata !== 16'h0) begin failures++; $display("FAIL reset_bdata got=%h exp=%h", bus_if.bdata, 16'h0); end
        rst_n = 1'b1;
        tick();
        // seg_en resets to all-on, seg_val to 0: digit 0 lights showing "0".
        checks++; if (seg_an !== 8'hFE)  begin failures++; $display("FAIL post_reset_seg_an got=%h exp=%h", seg_an, 8'hFE); end
        checks++; if (seg_cat !== 8'hC0) begin failures++; $display("FAIL post_reset_seg_cat got=%h exp=%h", seg_cat, 8'hC0); end
    endtask

    task automatic test_led;
        logic [15:0] e;
        exp_q.push_back(16'hA5A5);
        cpu_write(BASE + 32'h60, 32'h1234_A5A5);
        e = exp_q.pop_front();
        checks++; if (led !== e) begin failures++; $display("FAIL led_write got=%h exp=%h", led, e); end
        exp_q.push_back(16'hA5A5);
        cpu_write(BASE + 32'h6C, 32'h0000_1111);
        e = exp_q.pop_front();
        checks++; if (led !== e) begin failures++; $display("FAIL led_bad_addr got=%h exp=%h", led, e); end
        // Read strobe to the LED address must not write.
        bus_if.ioRead = 1'b1; bus_if.addr = BASE + 32'h60; bus_if.w_data = 32'h0000_0F0F;
        exp_q.push_back(16'hA5A5);
        tick();
        bus_idle();
        e = exp_q.pop_front();
        checks++; if (led !== e) begin failures++; $display("FAIL led_read_no_write got=%h exp=%h", led, e); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] vals [3];
        logic [15:0] e;
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        bus_if.ioWrite = 1'b1;
        bus_if.addr    = BASE + 32'h60;
        for (int i = 0; i < 3; i++) begin
            bus_if.w_data = {16'hDEAD, vals[i]};
            exp_q.push_back(vals[i]);
            tick();
            e = exp_q.pop_front();
            checks++; if (led !== e) begin failures++; $display("FAIL b2b_led[%0d] got=%h exp=%h", i, led, e); end
        end
        bus_idle();
        tick();
        checks++; if (led !== 16'h3333) begin failures++; $display("FAIL b2b_last_wins got=%h exp=%h", led, 16'h3333); end
    endtask

    task automatic test_switch;
        sw = 16'hBEEF;
        tick();
        checks++; if (bus_if.kdata !== 16'h0000) begin failures++; $display("FAIL sw_edge1 got=%h exp=%h", bus_if.kdata, 16'h0000); end
        tick();
        checks++; if (bus_if.kdata !== 16'hBEEF) begin failures++; $display("FAIL sw_edge2 got=%h exp=%h", bus_if.kdata, 16'hBEEF); end
    endtask

    task automatic test_debounce;
        logic [15:0] e;
        btn[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            exp_q.push_back((k == 6) ? 16'h0404 : 16'h0000);
            tick();
            e = exp_q.pop_front();
            checks++; if (bus_if.bdata !== e) begin failures++; $display("FAIL debounce_edge%0d got=%h exp=%h", k, bus_if.bdata, e); end
        end
        // Glitch on btn[0] shorter than the debounce window.
        btn[0] = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k == 3) btn[0] = 1'b0;
            exp_q.push_back(16'h0404);
            tick();
            e = exp_q.pop_front();
            checks++; if (bus_if.bdata !== e) begin failures++; $display("FAIL glitch_cycle%0d got=%h exp=%h", k, bus_if.bdata, e); end
        end
    endtask

    task automatic test_clear_on_read;
        // Read of a non-BTN address leaves the flags alone.
        bus_if.ioRead = 1'b1; bus_if.addr = BASE + 32'h70;
        tick();
        bus_idle();
        checks++; if (bus_if.bdata !== 16'h0404) begin failures++; $display("FAIL other_read_keeps got=%h exp=%h", bus_if.bdata, 16'h0404); end
        // BTN read shows pre-clear flags during the read cycle.
        bus_if.ioRead = 1'b1; bus_if.addr = BASE + 32'h74;
        #1;
        checks++; if (bus_if.bdata !== 16'h0404) begin failures++; $display("FAIL clear_read_cycle got=%h exp=%h", bus_if.bdata, 16'h0404); end
        tick();
        bus_idle();
        checks++; if (bus_if.bdata !== 16'h0004) begin failures++; $display("FAIL clear_after got=%h exp=%h", bus_if.bdata, 16'h0004); end
        // Release, then press again with the clear landing on the rising edge.
        btn[2] = 1'b0;
        repeat (6) tick();
        checks++; if (bus_if.bdata !== 16'h0000) begin failures++; $display("FAIL release got=%h exp=%h", bus_if.bdata, 16'h0000); end
        btn[2] = 1'b1;
        repeat (5) tick();
        checks++; if (bus_if.bdata !== 16'h0000) begin failures++; $display("FAIL repress_pending got=%h exp=%h", bus_if.bdata, 16'h0000); end
        bus_if.ioRead = 1'b1; bus_if.addr = BASE + 32'h74;
        tick();
        bus_idle();
        checks++; if (bus_if.bdata !== 16'h0404) begin failures++; $display("FAIL set_wins_edge got=%h exp=%h", bus_if.bdata, 16'h0404); end
        tick();
        checks++; if (bus_if.bdata !== 16'h0404) begin failures++; $display("FAIL set_wins_hold got=%h exp=%h", bus_if.bdata, 16'h0404); end
    endtask

    task automatic test_scan;
        logic [7:0] prev;
        logic [7:0] en;
        bit         found;
        scan_t      s;
        int         d;
        en = 8'h05;
        cpu_write(BASE + 32'h64, 32'h7654_3210);
        cpu_write(BASE + 32'h68, {24'h0, en});
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            prev = seg_an;
            tick();
            if (prev == 8'hFF && seg_an == 8'hFE) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL scan_sync got=%h exp=%h (no digit-0 start within bound)", seg_an, 8'hFE);
        end else begin
            for (int k = 0; k < 48; k++) begin
                d = (k / 3) % 8;
                s.an  = en[d] ? ~(8'h01 << d) : 8'hFF;
                s.cat = SEG_TBL[d];
                scan_q.push_back(s);
            end
            for (int k = 0; k < 48; k++) begin
                if (k > 0) tick();
                s = scan_q.pop_front();
                checks++;
                if (seg_an !== s.an || seg_cat !== s.cat) begin
                    failures++;
                    $display("FAIL scan_cycle%0d got an=%h cat=%h exp an=%h cat=%h", k, seg_an, seg_cat, s.an, s.cat);
                end
            end
        end
    endtask

    task automatic test_midrun_reset;
        // led=3333, kdata=BEEF, bdata=0404, display scanning.
        rst_n = 1'b0;
        #1;
        checks++; if (led !== 16'h0)     begin failures++; $display("FAIL mid_reset_led got=%h exp=%h", led, 16'h0); end
        checks++; if (seg_an !== 8'hFF)  begin failures++; $display("FAIL mid_reset_seg_an got=%h exp=%h", seg_an, 8'hFF); end
        checks++; if (seg_cat !== 8'hFF) begin failures++; $display("FAIL mid_reset_seg_cat got=%h exp=%h", seg_cat, 8'hFF); end
        checks++; if (bus_if.kdata !== 16'h0) begin failures++; $display("FAIL mid_reset_kdata got=%h exp=%h", bus_if.kdata, 16'h0); end
        checks++; if (bus_if.bdata !== 16'h0) begin failures++; $display("FAIL mid_reset_bdata got=%h exp=%h", bus_if.bdata, 16'h0); end
        tick();
        checks++; if (seg_an !== 8'hFF)  begin failures++; $display("FAIL held_reset_seg_an got=%h exp=%h", seg_an, 8'hFF); end
        rst_n = 1'b1;
        // btn[2] still held: the full sync + debounce delay starts over.
        repeat (5) tick();
        checks++; if (bus_if.bdata !== 16'h0000) begin failures++; $display("FAIL rst_debounce_lost got=%h exp=%h", bus_if.bdata, 16'h0000); end
        tick();
        checks++; if (bus_if.bdata !== 16'h0404) begin failures++; $display("FAIL rst_debounce_redo got=%h exp=%h", bus_if.bdata, 16'h0404); end
        checks++; if (bus_if.kdata !== 16'hBEEF) begin failures++; $display("FAIL rst_kdata_resync got=%h exp=%h", bus_if.kdata, 16'hBEEF); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_led();
        test_back_to_back();
        test_switch();
        test_debounce();
        test_clear_on_read();
        test_scan();
        test_midrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_periph.md
# io_periph

Peripheral-side responder for the CPU's memory-mapped IO path. It decodes `ioWrite`/`ioRead` with the ALU-computed address and store data from the CPU's IO/memory steering logic. Writes latch into LED, seven-segment and digit-enable registers. It supplies the read halves `kdata` (synchronized switches) and `bdata` (debounced buttons plus sticky press flags), which the CPU returns to the register file as `{kdata, bdata}`. It also multiplexes an 8-digit common-anode seven-segment display.

## Interface
- `BASE_ADDR`, default 32'hFFFF_FC00: IO window base; register offsets are added to it.
- `DEBOUNCE_CYCLES`, default 1_000_000: stable cycles required before a button change is accepted (10 ms at 100 MHz).
- `SCAN_DIV`, default 100_000: clock cycles per displayed digit.
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ioRead` in 1: CPU IO load in progress this cycle.
- `ioWrite` in 1: CPU IO store in progress this cycle.
- `addr` in 32: byte address from the ALU result.
- `w_data` in 32: store data; only sampled when `ioWrite`=1.
- `sw` in 16: raw switch pins, asynchronous.
- `btn` in 5: raw button pins, active-high, asynchronous.
- `kdata` out 16: synchronized switch value.
- `bdata` out 16: bits [4:0] are debounced levels; bits [12:8] are sticky press flags; all other bits are 0.
- `led` out 16: LED register.
- `seg_an` out 8: digit anodes, active-low, one-hot or all-high.
- `seg_cat` out 8: segments, active-low; [6:0]=gfedcba, [7]=dp (always 1).

## Operation
- **Address map** (offset from `BASE_ADDR`):
  - 0x60: LED. Write: `led` <= `w_data[15:0]`.
  - 0x64: SEG. Write: `seg_val` <= `w_data`. Digit i shows nibble `w_data[4i+3:4i]`.
  - 0x68: SEG_EN. Write: `seg_en` <= `w_data[7:0]`.
  - 0x74: BTN. Read clears the sticky flags.
  - Other addresses: writes are ignored; reads have no side effects. `kdata` and `bdata` are driven continuously regardless of address.
- **Switches**: 2-FF synchronizer; `kdata` = second stage.
- **Buttons**: per bit, a 2-FF synchronizer followed by the debouncer.
  - `cnt` increments while the synced value differs from `stable`, and resets to 0 while they are equal.
  - On the edge where `cnt`==`DEBOUNCE_CYCLES`-1 and the values still differ: `stable` flips and `cnt` goes to 0.
  - A glitch shorter than `DEBOUNCE_CYCLES` synced cycles never reaches `stable`.
- **Sticky flags**:
  - A rising edge of `stable[i]` sets `flag[i]`.
  - An edge with `ioRead`=1 and `addr`=BASE+0x74 clears all flags. `bdata` in that read cycle still shows the pre-clear flags.
  - If a set and a clear happen on the same edge for one bit, set wins.
- **Display scan**:
  - Prescaler counts 0..`SCAN_DIV`-1. At wrap, `digit` advances 0→1→…→7→0.
  - Registered outputs:
    - `seg_an` = ~(1<<`digit`) when `seg_en[digit]`=1; otherwise 8'hFF.
    - `seg_cat` = hex-decode of nibble `digit` of `seg_val`, covering 0-9 and A-F (b, d lowercase).
- **Reset values**:
  - `led`=0, `seg_val`=0, `seg_en`=8'hFF.
  - `kdata`=0, `bdata`=0; all sync stages, `stable`, flags and counters = 0.
  - `digit`=0, `seg_an`=8'hFF, `seg_cat`=8'hFF.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous). Debounce progress is lost.

## Timing
- **Write**: on the edge where `ioWrite`=1 and the address matches, the target register updates. It is visible on `led` in the following cycle, and on the display at the next `seg_an`/`seg_cat` register update (at most 1 cycle later).
- **Switches**: pin change to `kdata` takes 2 edges.
- **Buttons**: pin change to `bdata[i]` takes 2 + `DEBOUNCE_CYCLES` edges, provided the pin is held. The flag sets on the same edge as `bdata[i]` rises.
- **Reads** are single-cycle and combinational from registers. No wait states; no handshake beyond the `ioRead`/`ioWrite` strobes.
- **Back-to-back writes** on consecutive cycles all take effect. The last write to a register wins.
- **Scan**: each digit is held for `SCAN_DIV` cycles. `seg_an` and `seg_cat` lag `digit` by 1 cycle and change on the same edge, so there is no ghosting.

## Structure
- Shared package `io_pkg` holds:
  - Offset constants `IO_LED`, `IO_SEG`, `IO_SEGEN`, `IO_BTN`.
  - The hex→segment constant table.
  - Reset constants `SEG_OFF`=8'hFF and `SEGEN_RST`=8'hFF.
- One sub-module, `debouncer`, parameterized on `DEBOUNCE_CYCLES`, with ports `clk`, `rst_n`, `din`, `dout`. It contains the synchronizer, counter and stable register, and is instantiated once per button.
- Address decode, registers, flags and the scan logic live in `io_periph`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `SCAN_DIV`=3.
- Reset values: assert `rst_n`=0 mid-scan → next sample shows `led`=0, `seg_an`=8'hFF, `seg_cat`=8'hFF, `kdata`=0, `bdata`=0.
- LED write: `ioWrite`=1, `addr`=32'hFFFF_FC60, `w_data`=32'h1234_A5A5 → `led`=16'hA5A5 next cycle. The same write with `addr`=…FC6C leaves `led` unchanged.
- Debounce and flag:
  - `btn[2]` high for 6 cycles → `bdata`=16'h0404 after 6 edges.
  - A 3-cycle pulse on `btn[0]` → `bdata[0]` and `bdata[8]` stay 0.
- Clear-on-read: with flags=5'b00100, read …FC74 → `bdata`=16'h0404 that cycle, 16'h0004 next. A new debounced press of bit 2 landing on the clear edge leaves `bdata[10]`=1.
- Scan: write SEG=32'h7654_3210, then SEG_EN=8'h05 → `seg_an` cycles 8'hFE (`seg_cat`=8'hC0, "0") for 3 cycles, then 8'hFF for 3, then 8'hFB ("2"=8'hA4), and so on, wrapping after digit 7.
- Switch sync: `sw`=16'hBEEF → `kdata`=16'hBEEF on the 2nd edge, not the 1st.
